// File: rtl/riscv_pkg.sv
// riscv_pkg: opcode codes, register and tag sentinels, and the decoded
// instruction record handed from the decoder into the dispatch queue.
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 6;
    localparam int OPC_W = 7;
    localparam int ROB_W = 8;

    localparam logic [REG_W-1:0] NON_REG = 6'b100000;
    localparam logic [ROB_W:0]   NON_DEP = {1'b1, {ROB_W{1'b0}}};

    typedef enum logic [OPC_W-1:0] {
        lui   = 7'd1,  auipc = 7'd2,  jal   = 7'd3,  jalr  = 7'd4,
        beq   = 7'd5,  bne   = 7'd6,  blt   = 7'd7,  bge   = 7'd8,
        bltu  = 7'd9,  bgeu  = 7'd10, lb    = 7'd11, lh    = 7'd12,
        lw    = 7'd13, lbu   = 7'd14, lhu   = 7'd15, sb    = 7'd16,
        sh    = 7'd17, sw    = 7'd18, addi  = 7'd19, slti  = 7'd20,
        sltiu = 7'd21, xori  = 7'd22, ori   = 7'd23, andi  = 7'd24,
        slli  = 7'd25, srli  = 7'd26, srai  = 7'd27, add   = 7'd28,
        sub   = 7'd29, sll   = 7'd30, slt   = 7'd31, sltu  = 7'd32,
        xorr  = 7'd33, srl   = 7'd34, sra   = 7'd35, orr   = 7'd36,
        andd  = 7'd37
    } opcode_e;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [OPC_W-1:0] opcode;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic [XLEN-1:0]  imm;
        logic             pred;
    } iq_entry_t;

    // Loads and stores go to the load/store buffer.
    function automatic logic is_mem(input logic [OPC_W-1:0] op);
        return op >= lb && op <= sw;
    endfunction

    function automatic logic [REG_W-1:0] src1(input iq_entry_t e);
        if (e.opcode >= lui && e.opcode <= jal) return NON_REG;
        return {1'b0, e.rs1};
    endfunction

    function automatic logic [REG_W-1:0] src2(input iq_entry_t e);
        if (e.opcode >= lui && e.opcode <= jalr) return NON_REG;
        if (e.opcode >= lb && e.opcode <= lhu)   return NON_REG;
        if (e.opcode >= addi && e.opcode <= srai) return NON_REG;
        return {1'b0, e.rs2};
    endfunction

    // Branches, stores and writes to x0 produce no architectural result.
    function automatic logic [REG_W-1:0] dest(input iq_entry_t e);
        if (e.opcode >= beq && e.opcode <= bgeu) return NON_REG;
        if (e.opcode >= sb && e.opcode <= sw)    return NON_REG;
        if (e.rd == 5'd0)                        return NON_REG;
        return {1'b0, e.rd};
    endfunction

endpackage

// File: rtl/issue_fifo.sv
// issue_fifo: circular instruction queue between decode and dispatch.
// Ports: push/pop/clr control, din entry in, head entry out, count.
module issue_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   Sys_clk,
    input  logic                   Sys_rst,
    input  logic                   clr,
    input  logic                   push,
    input  logic                   pop,
    input  iq_entry_t              din,
    output iq_entry_t              head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    iq_entry_t     mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;

    assign head = mem[rptr];

    always_ff @(posedge Sys_clk) begin
        if (push) mem[wptr] <= din;
    end

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge Sys_clk) begin
        if (Sys_rst || clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

endmodule

// File: rtl/dispatch_unit.sv
// dispatch_unit: queues decoded instructions, renames and resolves operands,
// and issues one instruction per cycle to the RS or LSB with a RoB entry.
// Ports: decoder handshake (dc_*), RF lookup/rename (rf_*), RoB (rob_*),
// RS/LSB full and enables, registered issue payload (is_*), CDB snoop (cdb_*).
module dispatch_unit
    import riscv_pkg::*;
#(
    parameter int IQ_DEPTH  = 4,
    parameter int CDB_N     = 2,
    parameter int ROB_WIDTH = 8
) (
    input  logic                       Sys_clk,
    input  logic                       Sys_rst,
    input  logic                       Sys_rdy,
    input  logic                       flush,
    input  logic                       dc_valid,
    output logic                       dc_ready,
    input  logic [31:0]                dc_pc,
    input  logic [6:0]                 dc_opcode,
    input  logic [4:0]                 dc_rs1,
    input  logic [4:0]                 dc_rs2,
    input  logic [4:0]                 dc_rd,
    input  logic [31:0]                dc_imm,
    input  logic                       dc_pred,
    output logic [5:0]                 rf_rs1,
    output logic [5:0]                 rf_rs2,
    input  logic [ROB_WIDTH:0]         rf_Qj,
    input  logic [ROB_WIDTH:0]         rf_Qk,
    input  logic [31:0]                rf_Vj,
    input  logic [31:0]                rf_Vk,
    output logic                       rf_wr_en,
    output logic [5:0]                 rf_rd,
    output logic [ROB_WIDTH-1:0]       rf_rob_idx,
    input  logic                       rob_full,
    input  logic [ROB_WIDTH-1:0]       rob_idx,
    input  logic                       rob_Qj_ready,
    input  logic                       rob_Qk_ready,
    input  logic [31:0]                rob_Vj,
    input  logic [31:0]                rob_Vk,
    output logic                       rob_en,
    input  logic                       rs_full,
    input  logic                       lsb_full,
    output logic                       rs_en,
    output logic                       lsb_en,
    output logic [31:0]                is_pc,
    output logic [31:0]                is_imm,
    output logic [31:0]                is_Vj,
    output logic [31:0]                is_Vk,
    output logic [6:0]                 is_opcode,
    output logic [ROB_WIDTH:0]         is_Qj,
    output logic [ROB_WIDTH:0]         is_Qk,
    output logic [5:0]                 is_rd,
    output logic                       is_pred,
    output logic [ROB_WIDTH-1:0]       is_rob_idx,
    input  logic [CDB_N-1:0]           cdb_en,
    input  logic [CDB_N*ROB_WIDTH-1:0] cdb_idx,
    input  logic [CDB_N*32-1:0]        cdb_val
);

    localparam int CW = $clog2(IQ_DEPTH);
    localparam logic [ROB_WIDTH:0] TAG_ND = {1'b1, {ROB_WIDTH{1'b0}}};

    iq_entry_t          din;
    iq_entry_t          head;
    logic [CW:0]        count;
    logic               head_mem;
    logic               do_push;
    logic               do_issue;
    logic [ROB_WIDTH:0] qj;
    logic [ROB_WIDTH:0] qk;
    logic [XLEN-1:0]    vj;
    logic [XLEN-1:0]    vk;

    assign din = '{pc: dc_pc, opcode: dc_opcode, rs1: dc_rs1,
                   rs2: dc_rs2, rd: dc_rd, imm: dc_imm, pred: dc_pred};

    issue_fifo #(.DEPTH(IQ_DEPTH)) u_fifo (
        .Sys_clk (Sys_clk),
        .Sys_rst (Sys_rst),
        .clr     (flush),
        .push    (do_push),
        .pop     (do_issue),
        .din     (din),
        .head    (head),
        .count   (count)
    );

    assign dc_ready = count < (CW+1)'(IQ_DEPTH);
    assign do_push  = dc_valid && dc_ready && Sys_rdy && !flush;
    assign head_mem = is_mem(head.opcode);
    assign do_issue = (count != '0) && Sys_rdy && !flush && !rob_full
                   && !(head_mem ? lsb_full : rs_full);

    assign rf_rs1     = src1(head);
    assign rf_rs2     = src2(head);
    assign rf_rd      = is_rd;
    assign rf_rob_idx = is_rob_idx;

    // The RF rename written by last cycle's issue is not yet visible in
    // rf_Q*, so a matching destination is bypassed ahead of everything.
    function automatic void resolve(
        input  logic [REG_W-1:0]   src,
        input  logic [ROB_WIDTH:0] q_rf,
        input  logic [XLEN-1:0]    v_rf,
        input  logic               rob_rdy,
        input  logic [XLEN-1:0]    v_rob,
        output logic [ROB_WIDTH:0] q,
        output logic [XLEN-1:0]    v
    );
        logic hit;
        hit = 1'b0;
        q   = q_rf;
        v   = '0;
        if (src == NON_REG) begin
            q = TAG_ND;
        end else if (rf_wr_en && rf_rd == src) begin
            q = {1'b0, rf_rob_idx};
        end else if (q_rf[ROB_WIDTH]) begin
            q = TAG_ND;
            v = v_rf;
        end else if (rob_rdy) begin
            q = TAG_ND;
            v = v_rob;
        end else begin
            for (int k = 0; k < CDB_N; k++) begin
                if (!hit && cdb_en[k] &&
                    cdb_idx[k*ROB_WIDTH +: ROB_WIDTH] == q_rf[ROB_WIDTH-1:0]) begin
                    hit = 1'b1;
                    q   = TAG_ND;
                    v   = cdb_val[k*32 +: 32];
                end
            end
        end
    endfunction

    always_comb begin
        resolve(src1(head), rf_Qj, rf_Vj, rob_Qj_ready, rob_Vj, qj, vj);
        resolve(src2(head), rf_Qk, rf_Vk, rob_Qk_ready, rob_Vk, qk, vk);
    end

    always_ff @(posedge Sys_clk) begin
        if (Sys_rst) begin
            rs_en      <= 1'b0;
            lsb_en     <= 1'b0;
            rob_en     <= 1'b0;
            rf_wr_en   <= 1'b0;
            is_pc      <= '0;
            is_imm     <= '0;
            is_Vj      <= '0;
            is_Vk      <= '0;
            is_opcode  <= '0;
            is_Qj      <= TAG_ND;
            is_Qk      <= TAG_ND;
            is_rd      <= '0;
            is_pred    <= 1'b0;
            is_rob_idx <= '0;
        end else begin
            rs_en    <= do_issue && !head_mem;
            lsb_en   <= do_issue && head_mem;
            rob_en   <= do_issue;
            rf_wr_en <= do_issue;
            if (do_issue) begin
                is_pc      <= head.pc;
                is_imm     <= head.imm;
                is_opcode  <= head.opcode;
                is_pred    <= head.pred;
                is_rd      <= dest(head);
                is_rob_idx <= rob_idx;
                is_Qj      <= qj;
                is_Qk      <= qk;
                is_Vj      <= vj;
                is_Vk      <= vk;
            end
        end
    end

endmodule

// File: tb/tb_dispatch_unit.sv
// tb_dispatch_unit: vector table for operand resolution, directed corner
// sequences, and a randomized run against a queue-based reference model.
module tb_dispatch_unit;

    localparam int D = 4;
    localparam logic [8:0] ND = 9'h100;
    localparam logic [5:0] NR = 6'b100000;

    logic        Sys_clk = 1'b0;
    logic        Sys_rst, Sys_rdy, flush, dc_valid, dc_ready, dc_pred;
    logic [31:0] dc_pc, dc_imm;
    logic [6:0]  dc_opcode;
    logic [4:0]  dc_rs1, dc_rs2, dc_rd;
    logic [5:0]  rf_rs1, rf_rs2, rf_rd, is_rd;
    logic [8:0]  rf_Qj, rf_Qk, is_Qj, is_Qk;
    logic [31:0] rf_Vj, rf_Vk, rob_Vj, rob_Vk;
    logic        rf_wr_en, rob_full, rob_Qj_ready, rob_Qk_ready, rob_en;
    logic [7:0]  rf_rob_idx, rob_idx, is_rob_idx;
    logic        rs_full, lsb_full, rs_en, lsb_en, is_pred;
    logic [31:0] is_pc, is_imm, is_Vj, is_Vk;
    logic [6:0]  is_opcode;
    logic [1:0]  cdb_en;
    logic [15:0] cdb_idx;
    logic [63:0] cdb_val;

    always #5 Sys_clk = ~Sys_clk;

    dispatch_unit #(.IQ_DEPTH(D), .CDB_N(2), .ROB_WIDTH(8)) dut (
        .Sys_clk(Sys_clk), .Sys_rst(Sys_rst), .Sys_rdy(Sys_rdy),
        .flush(flush), .dc_valid(dc_valid), .dc_ready(dc_ready),
        .dc_pc(dc_pc), .dc_opcode(dc_opcode), .dc_rs1(dc_rs1),
        .dc_rs2(dc_rs2), .dc_rd(dc_rd), .dc_imm(dc_imm), .dc_pred(dc_pred),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_Qj(rf_Qj), .rf_Qk(rf_Qk),
        .rf_Vj(rf_Vj), .rf_Vk(rf_Vk), .rf_wr_en(rf_wr_en), .rf_rd(rf_rd),
        .rf_rob_idx(rf_rob_idx), .rob_full(rob_full), .rob_idx(rob_idx),
        .rob_Qj_ready(rob_Qj_ready), .rob_Qk_ready(rob_Qk_ready),
        .rob_Vj(rob_Vj), .rob_Vk(rob_Vk), .rob_en(rob_en),
        .rs_full(rs_full), .lsb_full(lsb_full), .rs_en(rs_en),
        .lsb_en(lsb_en), .is_pc(is_pc), .is_imm(is_imm), .is_Vj(is_Vj),
        .is_Vk(is_Vk), .is_opcode(is_opcode), .is_Qj(is_Qj), .is_Qk(is_Qk),
        .is_rd(is_rd), .is_pred(is_pred), .is_rob_idx(is_rob_idx),
        .cdb_en(cdb_en), .cdb_idx(cdb_idx), .cdb_val(cdb_val)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Sys_clk);
        #1;
    endtask

    task automatic idle();
        Sys_rst = 1'b0; Sys_rdy = 1'b1; flush = 1'b0; dc_valid = 1'b0;
        dc_pc = '0; dc_opcode = 7'd28; dc_rs1 = '0; dc_rs2 = '0;
        dc_rd = '0; dc_imm = '0; dc_pred = 1'b0;
        rf_Qj = ND; rf_Qk = ND; rf_Vj = '0; rf_Vk = '0;
        rob_full = 1'b0; rob_idx = '0; rob_Qj_ready = 1'b0;
        rob_Qk_ready = 1'b0; rob_Vj = '0; rob_Vk = '0;
        rs_full = 1'b0; lsb_full = 1'b0;
        cdb_en = '0; cdb_idx = '0; cdb_val = '0;
    endtask

    task automatic put(input logic [6:0] op, input logic [4:0] r1, r2, rd,
                       input logic [31:0] pc, imm);
        dc_valid = 1'b1; dc_opcode = op; dc_rs1 = r1; dc_rs2 = r2;
        dc_rd = rd; dc_pc = pc; dc_imm = imm; dc_pred = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        Sys_rst = 1'b1;
        step();
        Sys_rst = 1'b0;
    endtask

    // Reference model: instructions as records in a queue.
    typedef struct {
        logic [31:0] pc, imm;
        logic [6:0]  opc;
        logic [4:0]  rs1, rs2, rd;
        logic        pred;
    } ins_t;

    function automatic logic [5:0] s1(input ins_t e);
        if (e.opc >= 1 && e.opc <= 3) return NR;
        return {1'b0, e.rs1};
    endfunction

    function automatic logic [5:0] s2(input ins_t e);
        if ((e.opc >= 1 && e.opc <= 4) || (e.opc >= 11 && e.opc <= 15) ||
            (e.opc >= 19 && e.opc <= 27)) return NR;
        return {1'b0, e.rs2};
    endfunction

    function automatic logic [5:0] drd(input ins_t e);
        if ((e.opc >= 5 && e.opc <= 10) || (e.opc >= 16 && e.opc <= 18) ||
            e.rd == 5'd0) return NR;
        return {1'b0, e.rd};
    endfunction

    function automatic void mres(
        input logic [5:0] s, input logic [8:0] qrf, input logic [31:0] vrf,
        input logic rr, input logic [31:0] vr, input logic pw,
        input logic [5:0] prd, input logic [7:0] pidx,
        output logic [8:0] q, output logic [31:0] v);
        q = qrf;
        v = '0;
        if (s == NR) q = ND;
        else if (pw && prd == s) q = {1'b0, pidx};
        else if (qrf[8]) begin q = ND; v = vrf; end
        else if (rr) begin q = ND; v = vr; end
        else if (cdb_en[0] && cdb_idx[7:0] == qrf[7:0]) begin
            q = ND; v = cdb_val[31:0];
        end else if (cdb_en[1] && cdb_idx[15:8] == qrf[7:0]) begin
            q = ND; v = cdb_val[63:32];
        end
    endfunction

    typedef struct {
        logic [6:0]  op;
        logic [8:0]  q;
        logic [31:0] vrf;
        logic        rr;
        logic [31:0] vr;
        logic [1:0]  ce;
        logic [15:0] ci;
        logic [63:0] cv;
        logic [8:0]  eq;
        logic [31:0] ev;
    } vec_t;

    vec_t tbl[10];

    ins_t        mq[$];
    ins_t        h, ni;
    logic        pw, iss, psh, mm;
    logic [5:0]  prd;
    logic [7:0]  pidx;
    logic [31:0] e_pc, e_imm, e_vj, e_vk;
    logic [6:0]  e_op;
    logic [8:0]  e_qj, e_qk;
    logic [5:0]  e_rd;
    logic        e_pred;
    logic [7:0]  e_idx;
    logic [3:0]  e_en;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{7'd28, ND, 32'h1234, 1'b0, 32'h0, 2'b00, 16'h0, 64'h0, ND, 32'h1234};
        tbl[1] = '{7'd28, 9'h005, 32'h0, 1'b1, 32'h55, 2'b00, 16'h0, 64'h0, ND, 32'h55};
        tbl[2] = '{7'd28, 9'h005, 32'h0, 1'b0, 32'h0, 2'b01, 16'h0005, 64'hC0, ND, 32'hC0};
        tbl[3] = '{7'd28, 9'h007, 32'h0, 1'b0, 32'h0, 2'b11, 16'h0707,
                   {32'hB, 32'hA}, ND, 32'hA};
        tbl[4] = '{7'd28, 9'h007, 32'h0, 1'b0, 32'h0, 2'b10, 16'h0707,
                   {32'hB, 32'hA}, ND, 32'hB};
        tbl[5] = '{7'd28, 9'h006, 32'h0, 1'b0, 32'h0, 2'b11, 16'h0201,
                   {32'hB, 32'hA}, 9'h006, 32'h0};
        tbl[6] = '{7'd28, ND, 32'h3, 1'b1, 32'h9, 2'b00, 16'h0, 64'h0, ND, 32'h3};
        tbl[7] = '{7'd28, 9'h004, 32'h0, 1'b1, 32'h44, 2'b01, 16'h0004, 64'h99, ND, 32'h44};
        tbl[8] = '{7'd1, 9'h005, 32'h7, 1'b0, 32'h0, 2'b00, 16'h0, 64'h0, ND, 32'h0};
        tbl[9] = '{7'd29, ND, 32'hFFFF_FFFF, 1'b0, 32'h0, 2'b00, 16'h0, 64'h0, ND, 32'hFFFF_FFFF};

        do_reset();
        chk("rst_en", {rs_en, lsb_en, rob_en, rf_wr_en}, 4'b0000);
        chk("rst_q", {is_Qj, is_Qk}, {ND, ND});
        chk("rst_pay", {is_pc, is_imm, is_Vj, is_Vk}, 128'h0);
        chk("rst_rdy", dc_ready, 1'b1);

        for (int i = 0; i < 10; i++) begin
            do_reset();
            rf_Qj = tbl[i].q; rf_Qk = tbl[i].q;
            rf_Vj = tbl[i].vrf; rf_Vk = tbl[i].vrf;
            rob_Qj_ready = tbl[i].rr; rob_Qk_ready = tbl[i].rr;
            rob_Vj = tbl[i].vr; rob_Vk = tbl[i].vr;
            cdb_en = tbl[i].ce; cdb_idx = tbl[i].ci; cdb_val = tbl[i].cv;
            put(tbl[i].op, 5'd5, 5'd6, 5'd3, 32'h40 + i * 4, 32'h0);
            step();
            dc_valid = 1'b0;
            step();
            chk($sformatf("tbl%0d_j", i), {is_Qj, is_Vj}, {tbl[i].eq, tbl[i].ev});
            chk($sformatf("tbl%0d_k", i), {is_Qk, is_Vk}, {tbl[i].eq, tbl[i].ev});
            chk($sformatf("tbl%0d_en", i), {rs_en, lsb_en}, 2'b10);
        end

        // addi x1,x0,5: two-cycle latency from dc_valid to the enables.
        do_reset();
        put(7'd19, 5'd0, 5'd9, 5'd1, 32'h100, 32'd5);
        step();
        dc_valid = 1'b0;
        chk("addi_src", {rf_rs1, rf_rs2}, {6'd0, NR});
        chk("addi_lat", {rs_en, rob_en}, 2'b00);
        step();
        chk("addi_en", {rs_en, lsb_en, rob_en, rf_wr_en}, 4'b1011);
        chk("addi_pay", {is_Qj, is_Vj, is_rd, rf_rd, is_imm},
            {ND, 32'h0, 6'd1, 6'd1, 32'd5});
        step();
        chk("addi_pulse", {rs_en, lsb_en, rob_en, rf_wr_en}, 4'b0000);

        // add x2,x1,x1 behind addi x1: rename bypass.
        do_reset();
        rob_idx = 8'd3;
        put(7'd19, 5'd0, 5'd0, 5'd1, 32'h200, 32'd5);
        step();
        put(7'd28, 5'd1, 5'd1, 5'd2, 32'h204, 32'd0);
        step();
        dc_valid = 1'b0;
        rob_idx = 8'd4;
        chk("byp_first", {rs_en, is_rob_idx, rf_rob_idx}, {1'b1, 8'd3, 8'd3});
        chk("byp_src", {rf_rs1, rf_rs2}, {6'd1, 6'd1});
        step();
        chk("byp_second", {rs_en, is_Qj, is_Qk, is_rob_idx, is_rd},
            {1'b1, 9'd3, 9'd3, 8'd4, 6'd2});

        // Fill to full, refuse while full even on a dequeue, drain, wrap.
        do_reset();
        rs_full = 1'b1;
        for (int i = 0; i < D; i++) begin
            put(7'd28, 5'd1, 5'd2, 5'd3, 32'h300 + i * 4, 32'h0);
            step();
        end
        chk("fill_full", dc_ready, 1'b0);
        put(7'd28, 5'd1, 5'd2, 5'd3, 32'h999, 32'h0);
        rs_full = 1'b0;
        for (int i = 0; i < D; i++) begin
            step();
            dc_valid = 1'b0;
            chk($sformatf("drain%0d", i), {rs_en, is_pc}, {1'b1, 32'h300 + i * 4});
        end
        step();
        chk("drain_end", {rs_en, dc_ready}, 2'b01);
        put(7'd28, 5'd1, 5'd2, 5'd3, 32'h500, 32'h0);
        step();
        dc_valid = 1'b0;
        step();
        chk("wrap", {rs_en, is_pc}, {1'b1, 32'h500});

        // Flush with three queued and an issue otherwise possible.
        do_reset();
        rs_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            put(7'd28, 5'd1, 5'd2, 5'd3, 32'h600 + i * 4, 32'h0);
            step();
        end
        rs_full = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        dc_valid = 1'b0;
        chk("flush_en", {rs_en, lsb_en, rob_en, rf_wr_en, dc_ready}, 5'b00001);
        step();
        chk("flush_empty", {rs_en, lsb_en, rob_en}, 3'b000);

        // lw stalls on lsb_full even with RS room.
        do_reset();
        lsb_full = 1'b1;
        put(7'd13, 5'd1, 5'd7, 5'd4, 32'h700, 32'd8);
        step();
        dc_valid = 1'b0;
        chk("lw_src", {rf_rs1, rf_rs2}, {6'd1, NR});
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("lw_stall%0d", i), {rs_en, lsb_en}, 2'b00);
        end
        lsb_full = 1'b0;
        step();
        chk("lw_go", {rs_en, lsb_en, rob_en, is_pc}, {3'b011, 32'h700});

        // Randomized run against the queue model.
        do_reset();
        mq.delete();
        pw = 1'b0; prd = '0; pidx = '0;
        e_pc = '0; e_imm = '0; e_vj = '0; e_vk = '0; e_op = '0;
        e_qj = ND; e_qk = ND; e_rd = '0; e_pred = 1'b0; e_idx = '0;
        for (int c = 0; c < 800; c++) begin
            Sys_rst = ($urandom_range(0, 99) < 2);
            Sys_rdy = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 19) == 0);
            dc_valid = ($urandom_range(0, 9) < 6);
            dc_pc = $urandom; dc_imm = $urandom;
            dc_opcode = 7'($urandom_range(1, 37));
            dc_rs1 = 5'($urandom_range(0, 3));
            dc_rs2 = 5'($urandom_range(0, 3));
            dc_rd = 5'($urandom_range(0, 3));
            dc_pred = 1'($urandom);
            rf_Qj = $urandom_range(0, 1) ? ND : {1'b0, 8'($urandom_range(0, 3))};
            rf_Qk = $urandom_range(0, 1) ? ND : {1'b0, 8'($urandom_range(0, 3))};
            rf_Vj = $urandom; rf_Vk = $urandom;
            rob_Qj_ready = ($urandom_range(0, 3) == 0);
            rob_Qk_ready = ($urandom_range(0, 3) == 0);
            rob_Vj = $urandom; rob_Vk = $urandom;
            rob_full = ($urandom_range(0, 9) == 0);
            rob_idx = 8'($urandom);
            rs_full = ($urandom_range(0, 3) == 0);
            lsb_full = ($urandom_range(0, 3) == 0);
            cdb_en = 2'($urandom);
            cdb_idx = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))};
            cdb_val = {$urandom, $urandom};

            chk("rnd_rdy", dc_ready, mq.size() < D);
            if (mq.size() > 0)
                chk("rnd_src", {rf_rs1, rf_rs2}, {s1(mq[0]), s2(mq[0])});

            mm = 1'b0;
            if (mq.size() > 0) mm = (mq[0].opc >= 11 && mq[0].opc <= 18);
            iss = !Sys_rst && mq.size() > 0 && Sys_rdy && !flush && !rob_full
                  && !(mm ? lsb_full : rs_full);
            psh = !Sys_rst && dc_valid && mq.size() < D && Sys_rdy && !flush;
            ni = '{dc_pc, dc_imm, dc_opcode, dc_rs1, dc_rs2, dc_rd, dc_pred};
            e_en = 4'b0000;
            if (Sys_rst) begin
                mq.delete();
                e_pc = '0; e_imm = '0; e_vj = '0; e_vk = '0; e_op = '0;
                e_qj = ND; e_qk = ND; e_rd = '0; e_pred = 1'b0; e_idx = '0;
            end else begin
                if (iss) begin
                    h = mq.pop_front();
                    mres(s1(h), rf_Qj, rf_Vj, rob_Qj_ready, rob_Vj,
                         pw, prd, pidx, e_qj, e_vj);
                    mres(s2(h), rf_Qk, rf_Vk, rob_Qk_ready, rob_Vk,
                         pw, prd, pidx, e_qk, e_vk);
                    e_pc = h.pc; e_imm = h.imm; e_op = h.opc;
                    e_rd = drd(h); e_pred = h.pred; e_idx = rob_idx;
                    e_en = {!mm, mm, 2'b11};
                end
                if (psh) mq.push_back(ni);
                if (flush) mq.delete();
            end
            pw = e_en[0];
            prd = e_rd;
            pidx = e_idx;

            step();
            chk("rnd_en", {rs_en, lsb_en, rob_en, rf_wr_en}, e_en);
            chk("rnd_pay", {is_pc, is_imm, is_Vj, is_Vk}, {e_pc, e_imm, e_vj, e_vk});
            chk("rnd_tag",
                {is_opcode, is_Qj, is_Qk, is_rd, is_pred, is_rob_idx, rf_rd, rf_rob_idx},
                {e_op, e_qj, e_qk, e_rd, e_pred, e_idx, e_rd, e_idx});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
